axis_num_gen: RTL and testbench
===============================

Name: axis_num_gen

Overview:
- AXI-Stream traffic endpoint for NoC mesh bring-up.
- On a START pulse, the master side emits one packet of pseudo-random words from an LFSR, addressed to a fixed NoC destination.
- The slave side is a always-ready sink that counts received words and packets and sums their payloads.
- One instance attaches to each mesh node's user-side AXIS in/out pair.

Parameters:
- TDATAW, 32, tdata width.
- TDESTW, 4, tdest width.
- TIDW, 4, reserved; no TID ports exist.
- LFSR_DW, 8, LFSR width. Must satisfy 8 ≤ LFSR_DW ≤ TDATAW.
- LFSR_DEFAULT, 8'h01, LFSR seed loaded at reset. A seed of 0 is replaced by 1.
- PKT_LEN, 4, words per packet. Must be ≥ 1.
- DEST, 1, tdest value driven on every beat.

Ports:
- CLK  in  1  clock.
- RST_N  in  1  reset, asynchronous, active-low.
- START  in  1  single-cycle request to send one packet.
- AXIS_S_TVALID  in  1  sink valid.
- AXIS_S_TREADY  out  1  sink ready.
- AXIS_S_TDATA  in  TDATAW  sink data.
- AXIS_S_TLAST  in  1  sink last.
- AXIS_S_TDEST  in  TDESTW  sink dest; ignored.
- AXIS_M_TVALID  out  1  source valid.
- AXIS_M_TREADY  in  1  source ready.
- AXIS_M_TDATA  out  TDATAW  source data.
- AXIS_M_TLAST  out  1  source last.
- AXIS_M_TDEST  out  TDESTW  source dest.
- BUSY  out  1  packet in progress.
- RX_WORDS  out  32  received beat count.
- RX_PKTS  out  32  received TLAST count.
- RX_SUM  out  TDATAW  wrapping sum of received tdata.

Behaviour:
- Single clock. Reset is asynchronous and active-low. All flops clear or load on RST_N low.
- Reset values:
  - TVALID, TLAST, BUSY = 0.
  - AXIS_M_TDATA = 0.
  - AXIS_M_TDEST = DEST.
  - AXIS_S_TREADY = 0.
  - RX_WORDS, RX_PKTS, RX_SUM = 0.
  - LFSR = seed; word counter = 0.
- LFSR is Fibonacci, shift left: next = {lfsr[LFSR_DW-2:0], fb}. For LFSR_DW = 8, fb = b7^b5^b4^b3 (x^8+x^6+x^5+x^4+1). Other widths use a maximal-length tap table held in the package.
- Source FSM has two states, IDLE and SEND:
  - IDLE + START=1 → SEND on the next edge. TVALID=1 from the cycle after START. TDATA is the zero-extended current LFSR value. TLAST = (PKT_LEN==1). BUSY=1.
  - SEND: a beat transfers when TVALID && TREADY. On each transfer the LFSR advances, the counter increments, and TDATA loads the new LFSR value.
  - TLAST is asserted on beat PKT_LEN-1.
  - Transfer with TLAST → IDLE: TVALID=0, BUSY=0, counter=0.
  - While TVALID && !TREADY, TDATA, TLAST and TDEST hold stable and the LFSR does not advance.
  - START in SEND is ignored; START is not queued.
- LFSR state persists across packets and is reseeded only by reset.
- Sink:
  - AXIS_S_TREADY goes to 1 on the first edge after reset release and stays 1.
  - Each beat with S_TVALID && S_TREADY: RX_WORDS+1 and RX_SUM += TDATA, modulo 2^TDATAW.
  - RX_PKTS+1 when TLAST is also high.
  - All counters wrap.
- Source and sink are independent. Simultaneous send and receive is fully supported.
- Reset asserted mid-packet: the packet is aborted immediately (TVALID=0) and the LFSR returns to the seed.

Decomposition:
- Shared package num_gen_pkg holds:
  - the tap table and lfsr_next() function;
  - the FSM state enum {IDLE, SEND};
  - width defaults.
- One sub-module, lfsr_gen: ports CLK, RST_N, advance, state. Parameters LFSR_DW and seed.

Test Plan:
- Seed 8'h01, PKT_LEN=4, TREADY=1, pulse START → 4 beats on consecutive cycles: 0x01, 0x02, 0x04, 0x08. TLAST only on 0x08. TDEST=1 on all beats. BUSY falls after the last beat.
- Seed 8'h10, same conditions → 0x10, 0x21, 0x43, 0x86. A second START then yields 0x0D first (LFSR persistence).
- Seed 8'h01, TREADY toggled 1,0,0,1,... → every beat value held stable while stalled. Sequence unchanged: 0x01, 0x02, 0x04, 0x08.
- START re-pulsed during SEND → still exactly 4 beats, no second packet.
- Drive sink with beats 5, 7, 9 (TLAST on 9) → RX_WORDS=3, RX_PKTS=1, RX_SUM=21. TREADY=0 during reset and 1 one cycle after release.
- RST_N low after beat 2 → TVALID=0 immediately. After release plus a START, the first beat is 0x01.

Source files
------------

// File: rtl/num_gen_pkg.sv
// num_gen_pkg: shared definitions for the AXI-Stream number generator.
//   - default widths and packet shape
//   - source FSM state enum
//   - maximal-length LFSR tap table (widths 8..32) and lfsr_next()
package num_gen_pkg;

  localparam int unsigned TDATAW_DEF  = 32;
  localparam int unsigned TDESTW_DEF  = 4;
  localparam int unsigned TIDW_DEF    = 4;
  localparam int unsigned LFSR_DW_DEF = 8;
  localparam int unsigned PKT_LEN_DEF = 4;
  localparam int unsigned DEST_DEF    = 1;

  // Widest LFSR the tap table covers; states are zero-extended to this width.
  localparam int unsigned LFSR_MAX_W  = 32;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } src_state_e;

  // Feedback tap mask (bit n-1 set for polynomial term x^n), maximal length.
  function automatic logic [LFSR_MAX_W-1:0] lfsr_taps(input int unsigned dw);
    logic [LFSR_MAX_W-1:0] taps;
    case (dw)
      32'd8:   taps = 32'h0000_00B8;
      32'd9:   taps = 32'h0000_0110;
      32'd10:  taps = 32'h0000_0240;
      32'd11:  taps = 32'h0000_0500;
      32'd12:  taps = 32'h0000_0829;
      32'd13:  taps = 32'h0000_100D;
      32'd14:  taps = 32'h0000_2015;
      32'd15:  taps = 32'h0000_6000;
      32'd16:  taps = 32'h0000_D008;
      32'd17:  taps = 32'h0001_2000;
      32'd18:  taps = 32'h0002_0400;
      32'd19:  taps = 32'h0004_0023;
      32'd20:  taps = 32'h0009_0000;
      32'd21:  taps = 32'h0014_0000;
      32'd22:  taps = 32'h0030_0000;
      32'd23:  taps = 32'h0042_0000;
      32'd24:  taps = 32'h00E1_0000;
      32'd25:  taps = 32'h0120_0000;
      32'd26:  taps = 32'h0200_0023;
      32'd27:  taps = 32'h0400_0013;
      32'd28:  taps = 32'h0900_0000;
      32'd29:  taps = 32'h1400_0000;
      32'd30:  taps = 32'h2000_0029;
      32'd31:  taps = 32'h4800_0000;
      32'd32:  taps = 32'h8020_0003;
      default: taps = 32'h0000_00B8;
    endcase
    return taps;
  endfunction

  // Fibonacci step, shift left, feedback into bit 0; result masked to dw bits.
  function automatic logic [LFSR_MAX_W-1:0] lfsr_next(input logic [LFSR_MAX_W-1:0] cur,
                                                      input int unsigned dw);
    logic [LFSR_MAX_W-1:0] mask;
    logic                  fb;
    mask = (dw >= LFSR_MAX_W) ? 32'hFFFF_FFFF : ((32'h0000_0001 << dw) - 32'h0000_0001);
    fb   = ^(cur & lfsr_taps(dw) & mask);
    return ((cur << 1) | {31'h0000_0000, fb}) & mask;
  endfunction

endpackage

// File: rtl/lfsr_gen.sv
// lfsr_gen: free-standing LFSR register that steps once per cycle with advance.
//   CLK     in   clock
//   RST_N   in   asynchronous active-low reset, loads the seed
//   advance in   step the LFSR on this edge
//   state   out  current LFSR value (LFSR_DW bits)
module lfsr_gen
  import num_gen_pkg::*;
#(
  parameter int unsigned           LFSR_DW = LFSR_DW_DEF,
  parameter logic [LFSR_DW-1:0]    SEED    = LFSR_DW'(1'b1)
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic               advance,
  output logic [LFSR_DW-1:0] state
);

  // An all-zero LFSR would lock up, so a zero seed is promoted to 1.
  localparam logic [LFSR_DW-1:0] SEED_EFF = (SEED == {LFSR_DW{1'b0}}) ? LFSR_DW'(1'b1) : SEED;

  logic [LFSR_DW-1:0] state_q;
  logic [LFSR_DW-1:0] state_d;

  // Next LFSR value: step on advance, otherwise hold.
  always_comb begin
    if (advance) begin
      state_d = LFSR_DW'(lfsr_next(LFSR_MAX_W'(state_q), LFSR_DW));
    end else begin
      state_d = state_q;
    end
  end

  // LFSR register, reseeded only by reset.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= SEED_EFF;
    end else begin
      state_q <= state_d;
    end
  end

  assign state = state_q;

endmodule

// File: rtl/axis_num_gen.sv
// axis_num_gen: AXI-Stream traffic endpoint for NoC bring-up.
//   Source: on START emits one PKT_LEN-word packet of LFSR words to DEST.
//   Sink:   always ready; counts beats, TLASTs, and a wrapping payload sum.
// Ports:
//   CLK, RST_N (async active-low), START (one-cycle request)
//   AXIS_S_* : sink side (TVALID/TDATA/TLAST/TDEST in, TREADY out)
//   AXIS_M_* : source side (TVALID/TDATA/TLAST/TDEST out, TREADY in)
//   BUSY     : packet in progress
//   RX_WORDS, RX_PKTS, RX_SUM : sink statistics
module axis_num_gen
  import num_gen_pkg::*;
#(
  parameter int unsigned         TDATAW       = TDATAW_DEF,
  parameter int unsigned         TDESTW       = TDESTW_DEF,
  parameter int unsigned         TIDW         = TIDW_DEF,
  parameter int unsigned         LFSR_DW      = LFSR_DW_DEF,
  parameter logic [LFSR_DW-1:0]  LFSR_DEFAULT = LFSR_DW'(8'h01),
  parameter int unsigned         PKT_LEN      = PKT_LEN_DEF,
  parameter logic [TDESTW-1:0]   DEST         = TDESTW'(DEST_DEF)
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              START,
  input  logic              AXIS_S_TVALID,
  output logic              AXIS_S_TREADY,
  input  logic [TDATAW-1:0] AXIS_S_TDATA,
  input  logic              AXIS_S_TLAST,
  input  logic [TDESTW-1:0] AXIS_S_TDEST,
  output logic              AXIS_M_TVALID,
  input  logic              AXIS_M_TREADY,
  output logic [TDATAW-1:0] AXIS_M_TDATA,
  output logic              AXIS_M_TLAST,
  output logic [TDESTW-1:0] AXIS_M_TDEST,
  output logic              BUSY,
  output logic [31:0]       RX_WORDS,
  output logic [31:0]       RX_PKTS,
  output logic [TDATAW-1:0] RX_SUM
);

  localparam int unsigned CNTW = (PKT_LEN > 32'd1) ? $clog2(PKT_LEN) : 32'd1;

  src_state_e          state_q, state_d;
  logic [CNTW-1:0]     cnt_q, cnt_d;
  logic                tvalid_q, tvalid_d;
  logic                tlast_q, tlast_d;
  logic                busy_q, busy_d;
  logic [TDATAW-1:0]   tdata_q, tdata_d;
  logic [TDESTW-1:0]   tdest_q, tdest_d;
  logic                s_tready_q, s_tready_d;
  logic [31:0]         rx_words_q, rx_words_d;
  logic [31:0]         rx_pkts_q, rx_pkts_d;
  logic [TDATAW-1:0]   rx_sum_q, rx_sum_d;
  logic [LFSR_DW-1:0]  lfsr_state_s;
  logic                advance_s;
  logic                xfer_s;
  logic [CNTW-1:0]     cnt_inc_s;
  logic                last_next_s;
  logic                unused_s;

  // Sink TDEST is ignored and TIDW has no ports behind it.
  assign unused_s    = ^{AXIS_S_TDEST, TIDW[0]};

  assign xfer_s      = tvalid_q & AXIS_M_TREADY;
  assign cnt_inc_s   = cnt_q + CNTW'(1'b1);
  assign last_next_s = (cnt_inc_s == CNTW'(PKT_LEN - 32'd1));

  lfsr_gen #(
    .LFSR_DW (LFSR_DW),
    .SEED    (LFSR_DEFAULT)
  ) u_lfsr (
    .CLK     (CLK),
    .RST_N   (RST_N),
    .advance (advance_s),
    .state   (lfsr_state_s)
  );

  // Source FSM state register.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Source FSM next state; START outside IDLE is dropped, not queued.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (START) begin
          state_d = SEND;
        end else begin
          state_d = IDLE;
        end
      end
      SEND: begin
        if (xfer_s && tlast_q) begin
          state_d = IDLE;
        end else begin
          state_d = SEND;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Source outputs: values are prepared one cycle ahead so every output is a flop.
  always_comb begin
    tvalid_d  = tvalid_q;
    tlast_d   = tlast_q;
    busy_d    = busy_q;
    tdata_d   = tdata_q;
    cnt_d     = cnt_q;
    tdest_d   = DEST;
    advance_s = 1'b0;
    case (state_q)
      IDLE: begin
        if (START) begin
          tvalid_d = 1'b1;
          busy_d   = 1'b1;
          tdata_d  = TDATAW'(lfsr_state_s);
          tlast_d  = (PKT_LEN == 32'd1);
          cnt_d    = {CNTW{1'b0}};
        end else begin
          tvalid_d = 1'b0;
          busy_d   = 1'b0;
        end
      end
      SEND: begin
        if (xfer_s) begin
          // Present the value the LFSR is stepping to on this same edge.
          advance_s = 1'b1;
          tdata_d   = TDATAW'(lfsr_next(LFSR_MAX_W'(lfsr_state_s), LFSR_DW));
          if (tlast_q) begin
            tvalid_d = 1'b0;
            busy_d   = 1'b0;
            tlast_d  = 1'b0;
            cnt_d    = {CNTW{1'b0}};
          end else begin
            cnt_d    = cnt_inc_s;
            tlast_d  = last_next_s;
          end
        end else begin
          advance_s = 1'b0;
        end
      end
      default: begin
        tvalid_d = 1'b0;
        busy_d   = 1'b0;
        tlast_d  = 1'b0;
        cnt_d    = {CNTW{1'b0}};
      end
    endcase
  end

  // Sink statistics: always ready once out of reset, all counters wrap.
  always_comb begin
    s_tready_d = 1'b1;
    if (AXIS_S_TVALID && s_tready_q) begin
      rx_words_d = rx_words_q + 32'd1;
      rx_pkts_d  = rx_pkts_q + {31'd0, AXIS_S_TLAST};
      rx_sum_d   = rx_sum_q + AXIS_S_TDATA;
    end else begin
      rx_words_d = rx_words_q;
      rx_pkts_d  = rx_pkts_q;
      rx_sum_d   = rx_sum_q;
    end
  end

  // Source datapath and sink registers.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      tvalid_q   <= 1'b0;
      tlast_q    <= 1'b0;
      busy_q     <= 1'b0;
      tdata_q    <= {TDATAW{1'b0}};
      tdest_q    <= DEST;
      cnt_q      <= {CNTW{1'b0}};
      s_tready_q <= 1'b0;
      rx_words_q <= 32'd0;
      rx_pkts_q  <= 32'd0;
      rx_sum_q   <= {TDATAW{1'b0}};
    end else begin
      tvalid_q   <= tvalid_d;
      tlast_q    <= tlast_d;
      busy_q     <= busy_d;
      tdata_q    <= tdata_d;
      tdest_q    <= tdest_d;
      cnt_q      <= cnt_d;
      s_tready_q <= s_tready_d;
      rx_words_q <= rx_words_d;
      rx_pkts_q  <= rx_pkts_d;
      rx_sum_q   <= rx_sum_d;
    end
  end

  assign AXIS_M_TVALID = tvalid_q;
  assign AXIS_M_TDATA  = tdata_q;
  assign AXIS_M_TLAST  = tlast_q;
  assign AXIS_M_TDEST  = tdest_q;
  assign BUSY          = busy_q;
  assign AXIS_S_TREADY = s_tready_q;
  assign RX_WORDS      = rx_words_q;
  assign RX_PKTS       = rx_pkts_q;
  assign RX_SUM        = rx_sum_q;

endmodule

// File: tb/tb_axis_num_gen.sv
// tb_axis_num_gen: randomized self-checking bench for axis_num_gen.
// Two instances share clock/reset: dut_a seeded 8'h01, dut_b seeded 8'h10.
module tb_axis_num_gen;

  localparam int PKT_LEN = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_a, start_b, m_tready_a, m_tready_b;
  logic        s_tvalid, s_tlast;
  logic [31:0] s_tdata;
  logic [3:0]  s_tdest;
  logic        s_tvalid_b, s_tlast_b;
  logic [31:0] s_tdata_b;
  logic [3:0]  s_tdest_b;

  logic        s_tready_a, m_tvalid_a, m_tlast_a, busy_a;
  logic [31:0] m_tdata_a, rx_words_a, rx_pkts_a, rx_sum_a;
  logic [3:0]  m_tdest_a;
  logic        s_tready_b, m_tvalid_b, m_tlast_b, busy_b;
  logic [31:0] m_tdata_b, rx_words_b, rx_pkts_b, rx_sum_b;
  logic [3:0]  m_tdest_b;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [7:0]  ref_lfsr_a, ref_lfsr_b;
  logic [31:0] ref_words, ref_pkts, ref_sum;

  bit          sel_b;
  logic        obs_tvalid, obs_tlast, obs_busy, obs_tready;
  logic [31:0] obs_tdata;
  logic [3:0]  obs_tdest;

  always #5 clk = ~clk;

  axis_num_gen u_dut_a (
    .CLK(clk), .RST_N(rst_n), .START(start_a),
    .AXIS_S_TVALID(s_tvalid), .AXIS_S_TREADY(s_tready_a), .AXIS_S_TDATA(s_tdata),
    .AXIS_S_TLAST(s_tlast), .AXIS_S_TDEST(s_tdest),
    .AXIS_M_TVALID(m_tvalid_a), .AXIS_M_TREADY(m_tready_a), .AXIS_M_TDATA(m_tdata_a),
    .AXIS_M_TLAST(m_tlast_a), .AXIS_M_TDEST(m_tdest_a),
    .BUSY(busy_a), .RX_WORDS(rx_words_a), .RX_PKTS(rx_pkts_a), .RX_SUM(rx_sum_a)
  );

  axis_num_gen #(.LFSR_DEFAULT(8'h10)) u_dut_b (
    .CLK(clk), .RST_N(rst_n), .START(start_b),
    .AXIS_S_TVALID(s_tvalid_b), .AXIS_S_TREADY(s_tready_b), .AXIS_S_TDATA(s_tdata_b),
    .AXIS_S_TLAST(s_tlast_b), .AXIS_S_TDEST(s_tdest_b),
    .AXIS_M_TVALID(m_tvalid_b), .AXIS_M_TREADY(m_tready_b), .AXIS_M_TDATA(m_tdata_b),
    .AXIS_M_TLAST(m_tlast_b), .AXIS_M_TDEST(m_tdest_b),
    .BUSY(busy_b), .RX_WORDS(rx_words_b), .RX_PKTS(rx_pkts_b), .RX_SUM(rx_sum_b)
  );

  always_comb begin
    obs_tvalid = sel_b ? m_tvalid_b : m_tvalid_a;
    obs_tlast  = sel_b ? m_tlast_b  : m_tlast_a;
    obs_busy   = sel_b ? busy_b     : busy_a;
    obs_tdata  = sel_b ? m_tdata_b  : m_tdata_a;
    obs_tdest  = sel_b ? m_tdest_b  : m_tdest_a;
    obs_tready = sel_b ? m_tready_b : m_tready_a;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // x^8+x^6+x^5+x^4+1, shift left: new bit 0 is parity of bits 7,5,4,3.
  function automatic logic [7:0] ref_step(input logic [7:0] x);
    int v, fb;
    v  = int'(x);
    fb = ((v >> 7) ^ (v >> 5) ^ (v >> 4) ^ (v >> 3)) & 1;
    return 8'((v * 2 + fb) % 256);
  endfunction

  task automatic set_tready(input logic v);
    if (sel_b) m_tready_b = v;
    else       m_tready_a = v;
  endtask

  task automatic set_start(input logic v);
    if (sel_b) start_b = v;
    else       start_a = v;
  endtask

  function automatic logic ready_pattern(input int mode, input int cyc);
    logic [3:0] toggle_seq;
    toggle_seq = 4'b1001;  // cycle 0 -> bit 3: 1,0,0,1,...
    case (mode)
      1:       return toggle_seq[3 - (cyc % 4)];
      2:       return logic'($urandom_range(0, 1));
      default: return 1'b1;
    endcase
  endfunction

  // One packet: mode 0 ready always, 1 toggled, 2 random. abort_after>0 returns mid-packet.
  task automatic run_packet(input bit use_b, input int mode, input bit repulse, input int abort_after);
    logic [7:0]  exp_q[$];
    logic [31:0] hold_data;
    logic        hold_last;
    bit          stalled;
    int          beat, cyc;
    sel_b = use_b;
    for (int i = 0; i < PKT_LEN; i++) begin
      if (use_b) begin exp_q.push_back(ref_lfsr_b); ref_lfsr_b = ref_step(ref_lfsr_b); end
      else       begin exp_q.push_back(ref_lfsr_a); ref_lfsr_a = ref_step(ref_lfsr_a); end
    end
    @(posedge clk); #1;
    set_start(1'b1);
    set_tready(ready_pattern(mode, 0));
    @(posedge clk); #1;
    set_start(1'b0);
    beat = 0; cyc = 0; stalled = 0;
    while (beat < PKT_LEN && cyc < 40) begin
      @(negedge clk);
      if (cyc == 0 || obs_tvalid !== 1'b1) check("tvalid_in_pkt", 32'(obs_tvalid), 32'd1);
      if (cyc == 0 || obs_busy !== 1'b1)   check("busy_in_pkt", 32'(obs_busy), 32'd1);
      if (stalled) begin
        check("stall_hold_data", obs_tdata, hold_data);
        check("stall_hold_last", 32'(obs_tlast), 32'(hold_last));
      end
      if (obs_tready) begin
        check("beat_data", obs_tdata, 32'(exp_q[beat]));
        check("beat_last", 32'(obs_tlast), 32'(beat == PKT_LEN - 1));
        check("beat_dest", 32'(obs_tdest), 32'd1);
        beat++;
        stalled = 0;
      end else begin
        stalled   = 1;
        hold_data = obs_tdata;
        hold_last = obs_tlast;
      end
      if (abort_after > 0 && beat == abort_after) return;
      @(posedge clk); #1;
      cyc++;
      set_tready(ready_pattern(mode, cyc));
      if (repulse) set_start(cyc == 1 || cyc == 2);
    end
    set_start(1'b0);
    check("beat_count", 32'(beat), 32'(PKT_LEN));
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("idle_tvalid", 32'(obs_tvalid), 32'd0);
      check("idle_busy", 32'(obs_busy), 32'd0);
      @(posedge clk); #1;
    end
  endtask

  task automatic sink_beat(input logic v, input logic [31:0] d, input logic l);
    s_tvalid = v; s_tdata = d; s_tlast = l;
    if (v) begin
      ref_words = ref_words + 32'd1;
      ref_sum   = ref_sum + d;
      if (l) ref_pkts = ref_pkts + 32'd1;
    end
    @(posedge clk); #1;
  endtask

  task automatic check_sink(input string tag);
    @(negedge clk);
    check({tag, "_words"}, rx_words_a, ref_words);
    check({tag, "_pkts"}, rx_pkts_a, ref_pkts);
    check({tag, "_sum"}, rx_sum_a, ref_sum);
  endtask

  task automatic reset_model();
    ref_lfsr_a = 8'h01; ref_lfsr_b = 8'h10;
    ref_words = 32'd0; ref_pkts = 32'd0; ref_sum = 32'd0;
  endtask

  initial begin
    rst_n = 1'b0;
    start_a = 1'b0; start_b = 1'b0; m_tready_a = 1'b1; m_tready_b = 1'b1;
    s_tvalid = 1'b0; s_tdata = 32'd0; s_tlast = 1'b0; s_tdest = 4'd3;
    s_tvalid_b = 1'b0; s_tdata_b = 32'd0; s_tlast_b = 1'b0; s_tdest_b = 4'd0;
    sel_b = 1'b0;
    reset_model();

    // Reset values
    repeat (3) @(posedge clk);
    #2;
    check("rst_tvalid", 32'(m_tvalid_a), 32'd0);
    check("rst_tlast", 32'(m_tlast_a), 32'd0);
    check("rst_busy", 32'(busy_a), 32'd0);
    check("rst_tdata", m_tdata_a, 32'd0);
    check("rst_tdest", 32'(m_tdest_a), 32'd1);
    check("rst_s_tready", 32'(s_tready_a), 32'd0);
    check("rst_rx_words", rx_words_a, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("s_tready_at_release", 32'(s_tready_a), 32'd0);
    @(negedge clk);
    check("s_tready_after_release", 32'(s_tready_a), 32'd1);
    @(posedge clk); #1;

    // Basic packet, seed 01 and seed 10 (with persistence on dut_b)
    run_packet(1'b0, 0, 1'b0, 0);
    run_packet(1'b1, 0, 1'b0, 0);
    run_packet(1'b1, 0, 1'b0, 0);
    // START re-pulsed during SEND
    run_packet(1'b0, 0, 1'b1, 0);
    // Random backpressure
    for (int p = 0; p < 3; p++) run_packet(1'b0, 2, 1'b0, 0);

    // Directed sink beats 5, 7, 9
    sink_beat(1'b1, 32'd5, 1'b0);
    sink_beat(1'b0, 32'd99, 1'b1);
    sink_beat(1'b1, 32'd7, 1'b0);
    sink_beat(1'b1, 32'd9, 1'b1);
    sink_beat(1'b0, 32'd0, 1'b0);
    check_sink("sink_directed");
    check("sink_directed_sum_const", rx_sum_a, 32'd21);

    // Random sink traffic concurrent with a source packet on dut_b
    fork
      run_packet(1'b1, 2, 1'b0, 0);
      for (int i = 0; i < 30; i++)
        sink_beat(logic'($urandom_range(0, 1)), $urandom, logic'($urandom_range(0, 1)));
    join
    sink_beat(1'b0, 32'd0, 1'b0);
    check_sink("sink_random");

    // Reset asserted mid-packet
    @(posedge clk); #1;
    run_packet(1'b0, 0, 1'b0, 2);
    #1 rst_n = 1'b0;
    #1;
    check("midrst_tvalid", 32'(m_tvalid_a), 32'd0);
    check("midrst_busy", 32'(busy_a), 32'd0);
    m_tready_a = 1'b1;
    start_a = 1'b0;
    reset_model();
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_sink("sink_after_reset");
    // After reset, toggled backpressure still yields 01,02,04,08
    run_packet(1'b0, 1, 1'b0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1);
  end

endmodule
